// File: rtl/piso_tx.sv
// piso_tx: framed parallel-in serial-out transmitter (start, data, optional even parity, stop)
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit PARITY_EN = 1'b1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]       st_q, st_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d, ord;
    logic             par_q, par_d;
    logic             sout_q, sout_d, ready_q, ready_d, busy_q, busy_d, done_q, done_d;
    logic             accept;

    assign accept = load && ready_q;

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        sh_d  = sh_q;
        par_d = par_q;
        case (st_q)
            S_IDLE, S_STOP: begin
                st_d = accept ? S_START : S_IDLE;
                sh_d = accept ? din : sh_q;
                par_d = accept ? ^din : par_q;
            end
            S_START: begin
                st_d  = S_DATA;
                cnt_d = '0;
            end
            S_DATA: begin
                st_d  = (cnt_q == CW'(WIDTH - 1)) ? (PARITY_EN ? S_PARITY : S_STOP) : S_DATA;
                cnt_d = (cnt_q == CW'(WIDTH - 1)) ? cnt_q : cnt_q + 1'b1;
            end
            S_PARITY: st_d = S_STOP;
            default:  st_d = S_IDLE;
        endcase
    end

    // Bit order is resolved once so DATA always indexes by the counter directly.
    for (genvar i = 0; i < WIDTH; i++) begin : g_ord
        assign ord[i] = MSB_FIRST ? sh_d[WIDTH-1-i] : sh_d[i];
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        sout_d  = (st_d == S_START) ? 1'b1 :
                  (st_d == S_DATA) ? ord[cnt_d] :
                  (st_d == S_PARITY) ? par_d : 1'b0;
        ready_d = (st_d == S_IDLE) || (st_d == S_STOP);
        busy_d  = (st_d != S_IDLE);
        done_d  = (st_d == S_STOP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= S_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            sout_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            sout_q  <= sout_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sout  = sout_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: randomized and directed checks of piso_tx against a frame-level model
module tb_piso_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = '0, din2 = '0;
    logic       load = 1'b0, load2 = 1'b0;
    logic       ready, sout, busy, done;
    logic       ready2, sout2, busy2, done2;
    int         n_tests = 0;
    int         n_fail = 0;
    bit         exp_bits[0:15];

    always #5 clk = ~clk;

    piso_tx dut (
        .clk(clk), .rst(rst), .din(din), .load(load),
        .ready(ready), .sout(sout), .busy(busy), .done(done)
    );

    piso_tx #(.WIDTH(8), .PARITY_EN(1'b0), .MSB_FIRST(1'b0)) dut2 (
        .clk(clk), .rst(rst), .din(din2), .load(load2),
        .ready(ready2), .sout(sout2), .busy(busy2), .done(done2)
    );

    // Frame = start 1, data in chosen order, optional even parity, stop 0.
    function automatic int build_frame(input logic [7:0] w, input bit msb, input bit par_en);
        int n;
        int ones;
        n = 0;
        ones = 0;
        exp_bits[n] = 1'b1;
        n = n + 1;
        for (int i = 0; i < 8; i++) begin
            exp_bits[n] = msb ? w[7-i] : w[i];
            ones = ones + int'(exp_bits[n]);
            n = n + 1;
        end
        if (par_en) begin
            exp_bits[n] = (ones % 2) == 1;
            n = n + 1;
        end
        exp_bits[n] = 1'b0;
        return n + 1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        load = 1'b1;
        din = 8'hFF;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        load = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_tests++;
            if ({sout, ready, busy, done} !== 4'b0100) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d got sout/ready/busy/done=%b exp 0100", k, {sout, ready, busy, done});
            end
        end
    endtask

    task automatic test_a5();
        int f;
        f = build_frame(8'hA5, 1'b1, 1'b1);
        din = 8'hA5;
        load = 1'b1;
        for (int k = 0; k < f; k++) begin
            @(negedge clk);
            load = 1'b0;
            n_tests++;
            if (sout !== exp_bits[k] || done !== (k == f - 1) || ready !== (k == f - 1) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL a5_frame cyc %0d got sout=%b done=%b ready=%b busy=%b exp sout=%b done=%b ready=%b busy=1",
                         k, sout, done, ready, busy, exp_bits[k], k == f - 1, k == f - 1);
            end
        end
        @(negedge clk);
        n_tests++;
        if ({sout, ready, busy, done} !== 4'b0100) begin
            n_fail++;
            $display("FAIL a5_idle got %b exp 0100", {sout, ready, busy, done});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words[2];
        int f;
        words[0] = 8'h3C;
        words[1] = 8'h01;
        din = words[0];
        load = 1'b1;
        for (int w = 0; w < 2; w++) begin
            f = build_frame(words[w], 1'b1, 1'b1);
            for (int k = 0; k < f; k++) begin
                @(negedge clk);
                n_tests++;
                if (sout !== exp_bits[k] || done !== (k == f - 1) || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_frame%0d cyc %0d got sout=%b done=%b busy=%b exp sout=%b done=%b busy=1",
                             w, k, sout, done, busy, exp_bits[k], k == f - 1);
                end
                load = (w == 0) && (k == f - 1);
                din = (k == f - 1) ? 8'h01 : 8'h3C;
            end
        end
        load = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || sout !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle got busy=%b sout=%b exp 0 0", busy, sout);
        end
    endtask

    task automatic test_ignore_load();
        int f;
        f = build_frame(8'hFF, 1'b1, 1'b1);
        din = 8'hFF;
        load = 1'b1;
        for (int k = 0; k < f; k++) begin
            @(negedge clk);
            n_tests++;
            if (sout !== exp_bits[k] || done !== (k == f - 1)) begin
                n_fail++;
                $display("FAIL ignore_frame cyc %0d got sout=%b done=%b exp sout=%b done=%b", k, sout, done, exp_bits[k], k == f - 1);
            end
            load = (k == 3);
            din = (k == 3) ? 8'h00 : 8'hFF;
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_tests++;
            if ({sout, ready, busy, done} !== 4'b0100) begin
                n_fail++;
                $display("FAIL ignore_idle cyc %0d got %b exp 0100", k, {sout, ready, busy, done});
            end
        end
    endtask

    task automatic test_lsb_no_parity();
        int f;
        f = build_frame(8'h01, 1'b0, 1'b0);
        din2 = 8'h01;
        load2 = 1'b1;
        for (int k = 0; k < f; k++) begin
            @(negedge clk);
            load2 = 1'b0;
            n_tests++;
            if (sout2 !== exp_bits[k] || done2 !== (k == f - 1)) begin
                n_fail++;
                $display("FAIL lsb_frame cyc %0d got sout=%b done=%b exp sout=%b done=%b", k, sout2, done2, exp_bits[k], k == f - 1);
            end
        end
        @(negedge clk);
        n_tests++;
        if ({sout2, ready2, busy2, done2} !== 4'b0100) begin
            n_fail++;
            $display("FAIL lsb_idle got %b exp 0100", {sout2, ready2, busy2, done2});
        end
    endtask

    task automatic test_reset_mid_frame();
        int f;
        f = build_frame(8'hA5, 1'b1, 1'b1);
        din = 8'hA5;
        load = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            load = 1'b0;
            n_tests++;
            if (sout !== exp_bits[k]) begin
                n_fail++;
                $display("FAIL abort_pre cyc %0d got sout=%b exp %b", k, sout, exp_bits[k]);
            end
        end
        rst = 1'b1;
        load = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        load = 1'b0;
        n_tests++;
        if ({sout, ready, busy, done} !== 4'b0100) begin
            n_fail++;
            $display("FAIL abort_reset got %b exp 0100", {sout, ready, busy, done});
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_tests++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_nodone cyc %0d got done=%b busy=%b exp 0 0", k, done, busy);
            end
        end
        din = 8'hA5;
        load = 1'b1;
        for (int k = 0; k < f; k++) begin
            @(negedge clk);
            load = 1'b0;
            n_tests++;
            if (sout !== exp_bits[k] || done !== (k == f - 1)) begin
                n_fail++;
                $display("FAIL abort_fresh cyc %0d got sout=%b done=%b exp sout=%b done=%b", k, sout, done, exp_bits[k], k == f - 1);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [7:0] w;
        int f;
        bit chain;
        w = 8'($urandom);
        din = w;
        load = 1'b1;
        for (int t = 0; t < 25; t++) begin
            f = build_frame(w, 1'b1, 1'b1);
            chain = $urandom_range(0, 1) == 1;
            for (int k = 0; k < f; k++) begin
                @(negedge clk);
                n_tests++;
                if (sout !== exp_bits[k] || done !== (k == f - 1) || ready !== (k == f - 1) || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rand_frame w=%h cyc %0d got sout=%b done=%b ready=%b busy=%b exp sout=%b done=%b",
                             w, k, sout, done, ready, busy, exp_bits[k], k == f - 1);
                end
                // Noise on load/din mid-frame must be ignored.
                load = (k == f - 1) ? chain : ($urandom_range(0, 3) == 0);
                din = 8'($urandom);
                if (k == f - 1) w = din;
            end
            if (!chain) begin
                load = 1'b0;
                @(negedge clk);
                n_tests++;
                if ({sout, ready, busy, done} !== 4'b0100) begin
                    n_fail++;
                    $display("FAIL rand_idle got %b exp 0100", {sout, ready, busy, done});
                end
                w = 8'($urandom);
                din = w;
                load = 1'b1;
            end
        end
        load = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_a5();
        test_back_to_back();
        test_ignore_load();
        test_lsb_no_parity();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
